// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared opcode, funct and request-class definitions for the instruction encoder
package instr_encoder_pkg;

    localparam int ALU_FUNCT_WIDTH = 4;

    typedef enum logic [1:0] {
        CLS_ALU_REG = 2'd0,
        CLS_ALU_IMM = 2'd1,
        CLS_LOAD    = 2'd2,
        CLS_STORE   = 2'd3
    } instr_class_e;

    typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_funct_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_WRITE  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational packing of request fields into an RV32I word with legality check
module instr_field_packer
    import instr_encoder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [1:0]                 cls,
    input  logic [ALU_FUNCT_WIDTH-1:0] funct,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [4:0]                 rd,
    input  logic [N-1:0]               immed,
    output logic [31:0]                word,
    output logic                       illegal
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       known;
    logic       is_shift;
    logic       imm_fits;
    logic       shamt_fits;

    always_comb begin
        f3       = F3_ADD_SUB;
        f7       = F7_BASE;
        known    = 1'b1;
        is_shift = 1'b0;
        case (funct)
            ALU_ADD:  f3 = F3_ADD_SUB;
            ALU_SUB:  begin f3 = F3_ADD_SUB; f7 = F7_ALT; end
            ALU_AND:  f3 = F3_AND;
            ALU_OR:   f3 = F3_OR;
            ALU_XOR:  f3 = F3_XOR;
            ALU_SLT:  f3 = F3_SLT;
            ALU_SLTU: f3 = F3_SLTU;
            ALU_SLL:  begin f3 = F3_SLL; is_shift = 1'b1; end
            ALU_SRL:  begin f3 = F3_SRL_SRA; is_shift = 1'b1; end
            ALU_SRA:  begin f3 = F3_SRL_SRA; f7 = F7_ALT; is_shift = 1'b1; end
            default:  known = 1'b0;
        endcase
    end

    // A 12-bit signed immediate fits when every bit above bit 11 equals the sign bit.
    assign imm_fits   = (immed[N-1:11] == '0) || (&immed[N-1:11]);
    assign shamt_fits = (immed[N-1:5] == '0);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cls)
            CLS_ALU_REG: begin
                word    = {f7, rs2, rs1, f3, rd, OPC_OP};
                illegal = !known;
            end
            CLS_ALU_IMM: begin
                if (is_shift) begin
                    word    = {f7, immed[4:0], rs1, f3, rd, OPC_OP_IMM};
                    illegal = !shamt_fits;
                end else begin
                    word    = {immed[11:0], rs1, f3, rd, OPC_OP_IMM};
                    illegal = !known || (funct == ALU_SUB) || !imm_fits;
                end
            end
            CLS_LOAD: begin
                word    = {immed[11:0], rs1, F3_WORD, rd, OPC_LOAD};
                illegal = !imm_fits;
            end
            default: begin
                word    = {immed[11:5], rs2, rs1, F3_WORD, immed[4:0], OPC_STORE};
                illegal = !imm_fits;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - request-to-RV32I encoder writing words to instruction memory at an auto-incrementing address
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int N         = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [N-1:0]               base_addr,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_class,
    input  logic [ALU_FUNCT_WIDTH-1:0] req_alu_funct,
    input  logic [4:0]                 req_rs1,
    input  logic [4:0]                 req_rs2,
    input  logic [4:0]                 req_rd,
    input  logic [N-1:0]               req_immed,
    output logic                       mem_we,
    input  logic                       mem_ready,
    output logic [N-1:0]               mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       err_illegal,
    output logic [7:0]                 err_count
);

    enc_state_e                 state;
    logic [1:0]                 r_class;
    logic [ALU_FUNCT_WIDTH-1:0] r_funct;
    logic [4:0]                 r_rs1;
    logic [4:0]                 r_rs2;
    logic [4:0]                 r_rd;
    logic [N-1:0]               r_immed;
    logic [31:0]                packed_word;
    logic                       packed_illegal;

    instr_field_packer #(.N(N)) u_packer (
        .cls     (r_class),
        .funct   (r_funct),
        .rs1     (r_rs1),
        .rs2     (r_rs2),
        .rd      (r_rd),
        .immed   (r_immed),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    // start wins over a simultaneous request, so ready is withheld while it is high.
    assign req_ready = rst_n && (state == ST_IDLE) && !start;

    // mem_addr doubles as the write-address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            r_class     <= '0;
            r_funct     <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_immed     <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err_illegal <= 1'b0;
            err_count   <= '0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr <= base_addr;
                    end else if (req_valid) begin
                        r_class <= req_class;
                        r_funct <= req_alu_funct;
                        r_rs1   <= req_rs1;
                        r_rs2   <= req_rs2;
                        r_rd    <= req_rd;
                        r_immed <= req_immed;
                        state   <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (packed_illegal) begin
                        err_illegal <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        mem_wdata <= packed_word;
                        mem_we    <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + N'(ADDR_STEP);
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter N, default 32, data/address bus width.
REQ-002 Parameter ADDR_STEP, default 4, byte increment of the write address per accepted instruction.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset is asynchronous and active-low.
REQ-005 start  in  1  pulse; load base_addr into address counter.
REQ-006 base_addr  in  N  first write address.
REQ-007 req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both high.
REQ-008 req_class  in  2  0=ALU_REG, 1=ALU_IMM, 2=LOAD, 3=STORE.
REQ-009 req_alu_funct  in  ALU_FUNCT_WIDTH  operation code, ALU classes only.
REQ-010 req_rs1, req_rs2, req_rd  in  5 each  register indices.
REQ-011 req_immed  in  N  signed immediate (shift amount for SLL/SRL/SRA).
REQ-012 mem_we / mem_ready  out / in  1 / 1  instruction-memory write handshake.
REQ-013 mem_addr, mem_wdata  out  N, 32  write address and encoded RV32I word.
REQ-014 err_illegal  out  1  one-cycle pulse on rejected request; err_count out 8, saturating reject count.

Function
REQ-015 FSM states IDLE, ENCODE, WRITE; req_ready high only in IDLE with start low.
REQ-016 IDLE->ENCODE on handshake; request fields registered.
REQ-017 ENCODE: word computed and registered; legal ->WRITE, illegal ->IDLE with err_illegal pulse, no write.
REQ-018 WRITE: mem_we high, mem_addr/mem_wdata stable until mem_ready high; on that cycle address += ADDR_STEP, ->IDLE.
REQ-019 Latency: handshake at cycle T gives mem_we high at T+2; minimum throughput one instruction per 3 cycles.
REQ-020 ALU_REG: opcode 0110011, funct3/funct7 per standard RV32I for ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
REQ-021 ALU_IMM: opcode 0010011, rs2 ignored; SUB illegal; shifts put req_immed[4:0] in bits 24:20, funct7 0100000 for SRA else 0.
REQ-022 LOAD: LW, opcode 0000011, funct3 010, I-type immediate; STORE: SW, opcode 0100011, funct3 010, imm[11:5] in 31:25, imm[4:0] in 11:7.
REQ-023 Illegal: I/S immediate outside -2048..2047; shift amount outside 0..31; unknown alu_funct in ALU classes.
REQ-024 start in IDLE loads counter, takes priority over simultaneous req_valid; start outside IDLE ignored.
REQ-025 Address counter wraps modulo 2^N without flag.
REQ-026 err_count saturates at 255; cleared only by reset.

Reset
REQ-027 rst_n low: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, err_illegal 0, err_count 0, req_ready 0 while asserted.
REQ-028 Reset mid-WRITE abandons the word immediately; mem_we drops asynchronously.

Structure
REQ-029 Opcode, funct3, funct7 and req_class constants live in the shared define headers beside the existing opcode/funct/alu_funct defines.
REQ-030 Combinational sub-module instr_field_packer (class, funct, regs, immed -> word, illegal) instantiated inside; FSM and counter in instr_encoder.

Verification
REQ-031 start base_addr=0x100; ALU_REG ADD rs1=1 rs2=2 rd=3 -> mem_addr 0x100, mem_wdata 0x002081B3 at T+2.
REQ-032 ALU_IMM ADD rs1=0 rd=5 immed=-1 -> 0xFFF00293; following LOAD rs1=1 rd=4 immed=0 -> 0x0000A203 at 0x104.
REQ-033 STORE rs1=1 rs2=2 immed=8 -> 0x0020A423; ALU_IMM SRA rs1=1 rd=1 immed=3 -> 0x4030D093.
REQ-034 ALU_IMM ADD immed=2048 -> err_illegal pulse, err_count 1, no mem_we, address unchanged.
REQ-035 mem_ready held low 5 cycles in WRITE -> mem_we/addr/wdata stable, req_ready low; base_addr=0xFFFFFFFC write -> next address 0x0.
REQ-036 rst_n low mid-WRITE -> mem_we 0 same cycle, outputs per REQ-027, next request encodes normally.
